// File: rtl/dac_frame_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC frame scheduler: iCE40 hard-SPI system-bus
// register addresses, the configuration values written to them, SPISR bit
// positions, the scheduler state enum and helpers that build frame words and
// per-state bus accesses.
// ---------------------------------------------------------------------------
package dac_pkg;

    // Hard-SPI system-bus register map
    localparam logic [7:0] ADDR_SPICR1  = 8'h09;
    localparam logic [7:0] ADDR_SPICR2  = 8'h0A;
    localparam logic [7:0] ADDR_SPISR   = 8'h0C;
    localparam logic [7:0] ADDR_SPITXDR = 8'h0D;
    localparam logic [7:0] ADDR_SPICSR  = 8'h0F;

    // Configuration values
    localparam logic [7:0] CR1_ENABLE  = 8'h80;
    localparam logic [7:0] CR2_MASTER  = 8'h80;
    localparam logic [7:0] CR2_CS_HOLD = 8'hC0;
    localparam logic [7:0] CSR_CS0     = 8'h01;

    // SPISR status bits
    localparam int SR_TIP_BIT  = 7;
    localparam int SR_TRDY_BIT = 4;

    typedef enum logic [3:0] {
        ST_INIT_CR1,
        ST_INIT_CR2,
        ST_INIT_CSR,
        ST_IDLE,
        ST_CS_ON,
        ST_POLL_HI,
        ST_TX_HI,
        ST_POLL_LO,
        ST_TX_LO,
        ST_POLL_END,
        ST_CS_OFF
    } sched_state_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } sb_access_t;

    // Frame word: channel number in the top two bits, data in the low twelve.
    function automatic logic [15:0] buildFrame(input logic [1:0] ch, input logic [11:0] data);
        return {ch, 2'b00, data};
    endfunction

    // Bus access issued by each state; IDLE issues none.
    function automatic sb_access_t accessFor(input sched_state_t st, input logic [15:0] frame);
        sb_access_t acc;
        acc = '0;
        case (st)
            ST_INIT_CR1: acc = '{wr: 1'b1, addr: ADDR_SPICR1,  data: CR1_ENABLE};
            ST_INIT_CR2: acc = '{wr: 1'b1, addr: ADDR_SPICR2,  data: CR2_MASTER};
            ST_INIT_CSR: acc = '{wr: 1'b1, addr: ADDR_SPICSR,  data: CSR_CS0};
            ST_CS_ON:    acc = '{wr: 1'b1, addr: ADDR_SPICR2,  data: CR2_CS_HOLD};
            ST_POLL_HI,
            ST_POLL_LO,
            ST_POLL_END: acc = '{wr: 1'b0, addr: ADDR_SPISR,   data: 8'h00};
            ST_TX_HI:    acc = '{wr: 1'b1, addr: ADDR_SPITXDR, data: frame[15:8]};
            ST_TX_LO:    acc = '{wr: 1'b1, addr: ADDR_SPITXDR, data: frame[7:0]};
            ST_CS_OFF:   acc = '{wr: 1'b1, addr: ADDR_SPICR2,  data: CR2_MASTER};
            default:     acc = '0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// dac_frame_scheduler_if
// System-bus link between the scheduler (master) and the DAC_SPI hard-IP
// wrapper (slave).
//   SB_Stb   : access strobe, held until acknowledged
//   SB_Wr    : 1 = write, 0 = read
//   SB_Addr  : register address
//   SB_WData : write data
//   SB_RData : read data, valid in the ack cycle
//   SB_Ack   : transfer acknowledge
// ---------------------------------------------------------------------------
interface dac_frame_scheduler_if;
    logic       SB_Stb;
    logic       SB_Wr;
    logic [7:0] SB_Addr;
    logic [7:0] SB_WData;
    logic [7:0] SB_RData;
    logic       SB_Ack;

    modport master (
        output SB_Stb, SB_Wr, SB_Addr, SB_WData,
        input  SB_RData, SB_Ack
    );

    modport slave (
        input  SB_Stb, SB_Wr, SB_Addr, SB_WData,
        output SB_RData, SB_Ack
    );
endinterface

// File: rtl/dac_frame_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter for up to four requesters. The grant is combinational
// from the request vector and the priority pointer; the pointer moves to the
// channel after the winner only when the grant is accepted.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : request vector
//   accept_i      : the current grant is taken this cycle
//   grant_o       : one-hot grant (all zero with no request)
//   idx_o         : index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] req_i,
    input  logic              accept_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [1:0]        idx_o
);

    logic [1:0] ptr_q;

    // Scan the channels starting at the pointer, wrapping past the last one;
    // the first requester found wins.
    always_comb begin
        int  c;
        logic found;
        grant_o = '0;
        idx_o   = 2'd0;
        found   = 1'b0;
        c       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(ptr_q) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!found && req_i[c]) begin
                found      = 1'b1;
                grant_o[c] = 1'b1;
                idx_o      = 2'(c);
            end
        end
    end

    // The next search begins one past the channel just served. With a single
    // channel this keeps the pointer at zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 2'd0;
        end else if (accept_i) begin
            ptr_q <= (idx_o == 2'(NUM_CH - 1)) ? 2'd0 : idx_o + 2'd1;
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// ---------------------------------------------------------------------------
// dac_frame_scheduler
// Arbitrates up to four DAC channel requesters and sequences the hard-SPI
// system-bus accesses that ship one 16-bit frame per grant: one-time init
// (enable, master mode, CS0), then per frame CS hold, TRDY polls around two
// TXDR writes, a final idle poll and CS release.
//
// Parameters:
//   NUM_CH      : number of requesters (1..4)
//   TIMEOUT_CYC : ack watchdog limit in cycles (watchdog build only)
// Ports:
//   i_Clock, i_Reset_n : clock, asynchronous active-low reset
//   i_Req              : per-channel level requests
//   i_Data             : channel k value at bits [12k+11:12k]
//   o_Grant            : one-cycle one-hot pulse when data is latched
//   o_Ready            : init sequence done
//   o_Busy             : frame in progress
//   o_Error            : sticky ack-timeout flag
//   sb                 : system-bus master port
//
// Build option: define DAC_SCHED_TIMEOUT_EN to enable the ack watchdog.
// Without it an access waits indefinitely for ack and o_Error stays 0.
// ---------------------------------------------------------------------------
module dac_frame_scheduler
    import dac_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic [NUM_CH-1:0]    i_Req,
    input  logic [NUM_CH*12-1:0] i_Data,
    output logic [NUM_CH-1:0]    o_Grant,
    output logic                 o_Ready,
    output logic                 o_Busy,
    output logic                 o_Error,
    dac_frame_scheduler_if.master sb
);

    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
        $error("NUM_CH must be in 1..4");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    sched_state_t      state_q;
    logic              stb_q;
    logic              wr_q;
    logic [7:0]        addr_q;
    logic [7:0]        wdata_q;
    logic [15:0]       frame_q;
    logic [NUM_CH-1:0] grant_q;
    logic              ready_q;
    logic              busy_q;

    logic [NUM_CH-1:0] arbGrant;
    logic [1:0]        arbIdx;
    logic              accept;
    logic [11:0]       selData;
    logic [15:0]       newFrame;
    sb_access_t        curAccess;
    sb_access_t        csOnAccess;
    logic              timeoutHit;
    logic              srTrdy;
    logic              srTip;
    logic              unusedSrBits;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk_i   (i_Clock),
        .rst_ni  (i_Reset_n),
        .req_i   (i_Req),
        .accept_i(accept),
        .grant_o (arbGrant),
        .idx_o   (arbIdx)
    );

    // Requests are only looked at in IDLE, where the strobe is always low.
    assign accept     = (state_q == ST_IDLE) && (|i_Req);
    assign selData    = i_Data[int'(arbIdx)*12 +: 12];
    assign newFrame   = buildFrame(arbIdx, selData);
    assign curAccess  = accessFor(state_q, frame_q);
    assign csOnAccess = accessFor(ST_CS_ON, newFrame);

    assign srTrdy       = sb.SB_RData[SR_TRDY_BIT];
    assign srTip        = sb.SB_RData[SR_TIP_BIT];
    assign unusedSrBits = ^{sb.SB_RData[6:5], sb.SB_RData[3:0]};

`ifdef DAC_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] ackCnt_q;
    logic             error_q;

    // Counts cycles the current strobe has waited for ack; restarts whenever
    // the strobe is low or the access completes.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ackCnt_q <= '0;
        end else if (!stb_q || sb.SB_Ack || timeoutHit) begin
            ackCnt_q <= '0;
        end else begin
            ackCnt_q <= ackCnt_q + 1'b1;
        end
    end

    assign timeoutHit = stb_q && !sb.SB_Ack && (ackCnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Once set, the error flag only clears through reset.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            error_q <= 1'b0;
        end else if (timeoutHit) begin
            error_q <= 1'b1;
        end
    end

    assign o_Error = error_q;
`else
    assign timeoutHit = 1'b0;
    assign o_Error    = 1'b0;
`endif

    // Scheduler FSM and bus sequencer. Every non-IDLE state issues one access:
    // the strobe rises with the state's address/data, is held until ack, then
    // drops for at least one cycle while the state advances. The grant cycle
    // in IDLE raises the CS-hold strobe directly so bus activity starts with
    // the grant.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_INIT_CR1;
            stb_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            frame_q <= 16'h0000;
            grant_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            grant_q <= '0;
            if (timeoutHit) begin
                stb_q   <= 1'b0;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                state_q <= ST_INIT_CR1;
            end else if (state_q == ST_IDLE) begin
                if (accept) begin
                    grant_q <= arbGrant;
                    frame_q <= newFrame;
                    busy_q  <= 1'b1;
                    state_q <= ST_CS_ON;
                    stb_q   <= 1'b1;
                    wr_q    <= csOnAccess.wr;
                    addr_q  <= csOnAccess.addr;
                    wdata_q <= csOnAccess.data;
                end
            end else if (!stb_q) begin
                stb_q   <= 1'b1;
                wr_q    <= curAccess.wr;
                addr_q  <= curAccess.addr;
                wdata_q <= curAccess.data;
            end else if (sb.SB_Ack) begin
                stb_q <= 1'b0;
                case (state_q)
                    ST_INIT_CR1: state_q <= ST_INIT_CR2;
                    ST_INIT_CR2: state_q <= ST_INIT_CSR;
                    ST_INIT_CSR: begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                    ST_CS_ON:    state_q <= ST_POLL_HI;
                    ST_POLL_HI:  if (srTrdy) state_q <= ST_TX_HI;
                    ST_TX_HI:    state_q <= ST_POLL_LO;
                    ST_POLL_LO:  if (srTrdy) state_q <= ST_TX_LO;
                    ST_TX_LO:    state_q <= ST_POLL_END;
                    ST_POLL_END: if (srTrdy && !srTip) state_q <= ST_CS_OFF;
                    ST_CS_OFF: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default:     state_q <= ST_INIT_CR1;
                endcase
            end
        end
    end

    assign o_Grant     = grant_q;
    assign o_Ready     = ready_q;
    assign o_Busy      = busy_q;
    assign sb.SB_Stb   = stb_q;
    assign sb.SB_Wr    = wr_q;
    assign sb.SB_Addr  = addr_q;
    assign sb.SB_WData = wdata_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dac_frame_scheduler
// Directed bench for dac_frame_scheduler with four channels. A bus slave
// model acks every access after the strobe has been high for one full cycle,
// logs each completed access as {wr, addr, data} and serves SPISR reads from
// a queue (0x10 once empty).
// ---------------------------------------------------------------------------
module tb_dac_frame_scheduler;

   logic        clock;
   logic        reset_n;
   logic [3:0]  req;
   logic [47:0] data;
   logic [3:0]  grant;
   logic        ready;
   logic        busy;
   logic        error;

   int checks = 0;
   int failures = 0;
   int gapViolations = 0;
   int highCnt = 0;
   bit holdTxAck = 0;

   logic [16:0] accessLog[$];
   logic [7:0]  statusQ[$];

   dac_frame_scheduler_if sbIf();

   dac_frame_scheduler #(.NUM_CH(4), .TIMEOUT_CYC(16)) dut (
      .i_Clock  (clock),
      .i_Reset_n(reset_n),
      .i_Req    (req),
      .i_Data   (data),
      .o_Grant  (grant),
      .o_Ready  (ready),
      .o_Busy   (busy),
      .o_Error  (error),
      .sb       (sbIf)
   );

   // Free-running clock, 10 time units per cycle
   initial clock = 0;
   always #5 clock = ~clock;

   // Bus slave: ack in the second cycle of each strobe, log the access, and
   // flag a strobe that is still high one cycle after its ack
   always @(negedge clock) begin
      if (sbIf.SB_Stb) begin
         if (sbIf.SB_Ack) gapViolations++;
         highCnt++;
         if (highCnt >= 2 && !(holdTxAck && sbIf.SB_Addr == 8'h0D)) begin
            sbIf.SB_Ack = 1'b1;
            if (!sbIf.SB_Wr && sbIf.SB_Addr == 8'h0C)
               sbIf.SB_RData = (statusQ.size() > 0) ? statusQ.pop_front() : 8'h10;
            else
               sbIf.SB_RData = 8'h00;
            accessLog.push_back({sbIf.SB_Wr, sbIf.SB_Addr,
                                 sbIf.SB_Wr ? sbIf.SB_WData : sbIf.SB_RData});
         end else begin
            sbIf.SB_Ack = 1'b0;
         end
      end else begin
         highCnt = 0;
         sbIf.SB_Ack = 1'b0;
      end
   end

   // Hard stop in case a bounded wait itself misbehaves
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, expected completion");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r, input logic [47:0] d);
      req  = r;
      data = d;
   endtask

   task automatic applyReset();
      @(negedge clock);
      reset_n = 0;
      repeat (2) @(negedge clock);
      accessLog.delete();
      reset_n = 1;
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, 32'(ready), 32'd1);
   endtask

   task automatic waitGrant(input string tag, output logic [3:0] g, output int n);
      n = 0;
      g = 4'b0;
      while (n < 100) begin
         @(negedge clock);
         n++;
         if (grant != 4'b0) break;
      end
      g = grant;
      checkOutput({tag, "_seen"}, 32'(g != 4'b0), 32'd1);
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clock);
         n++;
      end
      checkOutput(tag, 32'(busy), 32'd0);
   endtask

   task automatic checkInitLog(input string tag);
      checkOutput({tag, "_count"}, 32'(accessLog.size()), 32'd3);
      if (accessLog.size() >= 3) begin
         checkOutput({tag, "_cr1"}, 32'(accessLog[0]), 32'h109_80);
         checkOutput({tag, "_cr2"}, 32'(accessLog[1]), 32'h10A_80);
         checkOutput({tag, "_csr"}, 32'(accessLog[2]), 32'h10F_01);
      end
   endtask

   initial begin
      logic [3:0]  g;
      logic [16:0] expFrame[7];
      int          n;
      bit          found;

      reset_n = 0;
      sbIf.SB_Ack = 0;
      sbIf.SB_RData = 8'h00;
      applyStimulus(4'b0000, 48'h0);

      // Reset values
      repeat (3) @(negedge clock);
      checkOutput("rst_stb",   32'(sbIf.SB_Stb),   32'd0);
      checkOutput("rst_addr",  32'(sbIf.SB_Addr),  32'd0);
      checkOutput("rst_wdata", 32'(sbIf.SB_WData), 32'd0);
      checkOutput("rst_grant", 32'(grant),         32'd0);
      checkOutput("rst_ready", 32'(ready),         32'd0);
      checkOutput("rst_busy",  32'(busy),          32'd0);
      checkOutput("rst_error", 32'(error),         32'd0);

      // Init: first strobe on the first edge after release, then three writes
      reset_n = 1;
      @(negedge clock);
      checkOutput("init_first_stb",  32'(sbIf.SB_Stb),  32'd1);
      checkOutput("init_first_addr", 32'(sbIf.SB_Addr), 32'h09);
      checkOutput("init_not_ready",  32'(ready),        32'd0);
      waitReady("init_ready");
      checkInitLog("init");

      // Single frame: ch2 = 0xABC -> TXDR 0x8A, 0xBC
      accessLog.delete();
      applyStimulus(4'b0100, 48'h000_ABC_000_000);
      @(negedge clock);
      checkOutput("frame_grant",   32'(grant),        32'h4);
      checkOutput("frame_busy",    32'(busy),         32'd1);
      checkOutput("frame_cs_stb",  32'(sbIf.SB_Stb),  32'd1);
      checkOutput("frame_cs_addr", 32'(sbIf.SB_Addr), 32'h0A);
      applyStimulus(4'b0000, 48'h000_123_000_000);
      @(negedge clock);
      checkOutput("frame_grant_pulse", 32'(grant), 32'h0);
      waitIdle("frame_idle");
      expFrame = '{17'h10A_C0, 17'h00C_10, 17'h10D_8A, 17'h00C_10,
                   17'h10D_BC, 17'h00C_10, 17'h10A_80};
      checkOutput("frame_count", 32'(accessLog.size()), 32'd7);
      for (int i = 0; i < 7 && i < accessLog.size(); i++)
         checkOutput($sformatf("frame_acc%0d", i), 32'(accessLog[i]), 32'(expFrame[i]));

      // Round-robin from a fresh reset: all four requesting
      applyReset();
      waitReady("rr_ready");
      applyStimulus(4'b1111, 48'h111_222_333_444);
      for (int i = 0; i < 4; i++) begin
         waitGrant($sformatf("rr_grant%0d", i), g, n);
         checkOutput($sformatf("rr_order%0d", i), 32'(g), 32'(4'b0001 << i));
         if (i > 0) checkOutput($sformatf("rr_b2b%0d", i), 32'(n), 32'd1);
         req = req & ~g;
         if (i == 3) req = 4'b1001;
         waitIdle($sformatf("rr_idle%0d", i));
      end
      waitGrant("rr_wrap0", g, n);
      checkOutput("rr_wrap_ch0", 32'(g), 32'h1);
      req = req & ~g;
      waitIdle("rr_wrap_idle0");
      waitGrant("rr_wrap1", g, n);
      checkOutput("rr_wrap_ch3", 32'(g), 32'h8);
      req = req & ~g;
      waitIdle("rr_wrap_idle1");

      // TRDY polling: three not-ready reads before the high byte goes out
      accessLog.delete();
      statusQ = '{8'h00, 8'h00, 8'h00};
      gapViolations = 0;
      applyStimulus(4'b0010, 48'h000_000_5A3_000);
      waitGrant("poll_grant", g, n);
      req = 4'b0000;
      waitIdle("poll_idle");
      checkOutput("poll_count", 32'(accessLog.size()), 32'd10);
      if (accessLog.size() >= 6) begin
         checkOutput("poll_cs",    32'(accessLog[0]), 32'h10A_C0);
         checkOutput("poll_rd1",   32'(accessLog[1]), 32'h00C_00);
         checkOutput("poll_rd2",   32'(accessLog[2]), 32'h00C_00);
         checkOutput("poll_rd3",   32'(accessLog[3]), 32'h00C_00);
         checkOutput("poll_rd4",   32'(accessLog[4]), 32'h00C_10);
         checkOutput("poll_txhi",  32'(accessLog[5]), 32'h10D_45);
      end
      checkOutput("poll_stb_gap", 32'(gapViolations), 32'd0);

      // Reset during the low-byte write aborts the frame and replays init
      applyStimulus(4'b0001, 48'h000_000_000_555);
      waitGrant("rmid_grant", g, n);
      req = 4'b0000;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         found = sbIf.SB_Stb && sbIf.SB_Addr == 8'h0D && sbIf.SB_WData == 8'h55;
      end
      checkOutput("rmid_tx_lo_seen", 32'(found), 32'd1);
      #1 reset_n = 0;
      #1;
      checkOutput("rmid_stb",   32'(sbIf.SB_Stb), 32'd0);
      checkOutput("rmid_busy",  32'(busy),        32'd0);
      checkOutput("rmid_ready", 32'(ready),       32'd0);
      @(negedge clock);
      accessLog.delete();
      reset_n = 1;
      waitReady("rmid_ready_again");
      repeat (4) @(negedge clock);
      checkInitLog("rmid_init");

`ifdef DAC_SCHED_TIMEOUT_EN
      // Ack withheld on the high-byte write: strobe gives up after 16 cycles
      holdTxAck = 1;
      applyStimulus(4'b1000, 48'h0F0_000_000_000);
      waitGrant("to_grant", g, n);
      req = 4'b0000;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         found = sbIf.SB_Stb && sbIf.SB_Addr == 8'h0D;
      end
      checkOutput("to_tx_seen", 32'(found), 32'd1);
      n = 1;
      while (n < 100) begin
         @(negedge clock);
         if (!sbIf.SB_Stb) break;
         n++;
      end
      checkOutput("to_stb_cycles", 32'(n),     32'd16);
      checkOutput("to_error",      32'(error), 32'd1);
      checkOutput("to_ready",      32'(ready), 32'd0);
      checkOutput("to_busy",       32'(busy),  32'd0);
      holdTxAck = 0;
      accessLog.delete();
      waitReady("to_ready_again");
      checkInitLog("to_init");
      checkOutput("to_error_sticky", 32'(error), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
